// File: rtl/sample_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// sample_bus_sequencer_if
// Purpose : bundles the command bus, the per-channel request levels, the FIFO
//           back-pressure and the shared sample-bus outputs of the sample bus
//           sequencer into one interface.
// Modports:
//   master - the side that issues commands and raises requests (pincontrols,
//            command master, sample_collector); observes the bus outputs
//   slave  - the sequencer itself
// Signals :
//   cmd_bus_en / cmd_bus_wr / cmd_bus_addr[15:0] / cmd_bus_data[31:0]
//   channel_request[NUM_CHANNELS-1:0]  per-channel "sample pending" level
//   sample_fifo_almost_full            back-pressure from the collector
//   channel_select[7:0]                granted channel, 8'hFF = none
//   output_sample                      one-cycle drive strobe
//   busy                               high while a grant occupies the bus
//   grant_count[31:0]                  grants issued (0 unless stats built)
// -----------------------------------------------------------------------------
interface sample_bus_sequencer_if #(
  parameter int NUM_CHANNELS = 50
);
  logic                    cmd_bus_en;
  logic                    cmd_bus_wr;
  logic [15:0]             cmd_bus_addr;
  logic [31:0]             cmd_bus_data;
  logic [NUM_CHANNELS-1:0] channel_request;
  logic                    sample_fifo_almost_full;
  logic [7:0]              channel_select;
  logic                    output_sample;
  logic                    busy;
  logic [31:0]             grant_count;

  modport master (
    output cmd_bus_en, cmd_bus_wr, cmd_bus_addr, cmd_bus_data,
    output channel_request, sample_fifo_almost_full,
    input  channel_select, output_sample, busy, grant_count
  );

  modport slave (
    input  cmd_bus_en, cmd_bus_wr, cmd_bus_addr, cmd_bus_data,
    input  channel_request, sample_fifo_almost_full,
    output channel_select, output_sample, busy, grant_count
  );
endinterface

// File: rtl/sample_bus_sequencer.sv
// -----------------------------------------------------------------------------
// sample_bus_sequencer
// Purpose : owns the shared sample bus. Polls channels round-robin, one
//           candidate per cycle, and grants the bus to an enabled channel with
//           a pending sample while the sample FIFO is not almost full. A grant
//           is a one-cycle output_sample strobe followed by HOLD_CYCLES cycles
//           with channel_select held so the pin can settle the data bus.
// Ports   :
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - sample_bus_sequencer_if.slave (command bus, requests,
//          back-pressure, channel_select/output_sample/busy/grant_count)
// Commands (address POSITION, op = cmd_bus_data[31:30]):
//   00 clear enable mask and grant_count, 01 enable ch data[7:0],
//   10 disable ch data[7:0], 11 run <= data[0]
// Build option:
//   SAMPLE_SEQ_STATS_EN - when defined grant_count is a live 32-bit counter,
//                         otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module sample_bus_sequencer #(
  parameter int POSITION     = 242,
  parameter int NUM_CHANNELS = 50,
  parameter int HOLD_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sample_bus_sequencer_if.slave  bus
);

  localparam logic [15:0]             POS_ADDR = 16'(POSITION);
  localparam logic [7:0]              LAST_CH  = 8'(NUM_CHANNELS - 1);
  localparam logic [3:0]              HOLD_LD  = 4'(HOLD_CYCLES - 1);
  localparam logic [NUM_CHANNELS-1:0] ONE_HOT0 = NUM_CHANNELS'(1);
  localparam logic [7:0]              NO_CH    = 8'hFF;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                  r_state;
  logic [7:0]              r_ptr;
  logic [7:0]              r_sel;
  logic [3:0]              r_hold;
  logic [NUM_CHANNELS-1:0] r_mask;
  logic                    r_run;
  logic                    r_strobe;
  logic                    r_busy;

  logic                    w_cmd;
  logic [1:0]              w_op;
  logic [7:0]              w_idx;
  logic                    w_idx_ok;
  logic [NUM_CHANNELS-1:0] w_idx_bit;
  logic [NUM_CHANNELS-1:0] w_cand;
  logic                    w_grant;
  logic                    w_unused_bits;

  function automatic logic [7:0] next_ch(input logic [7:0] ch);
    return (ch == LAST_CH) ? 8'd0 : ch + 8'd1;
  endfunction

  assign w_cmd         = bus.cmd_bus_en & bus.cmd_bus_wr & (bus.cmd_bus_addr == POS_ADDR);
  assign w_op          = bus.cmd_bus_data[31:30];
  assign w_idx         = bus.cmd_bus_data[7:0];
  assign w_idx_ok      = (w_idx <= LAST_CH);
  assign w_idx_bit     = ONE_HOT0 << w_idx;
  assign w_unused_bits = &{1'b0, bus.cmd_bus_data[29:8]};

  // Bit 0 of the shifted vector is the current candidate; registered mask and
  // run are used, so a command accepted this cycle only affects later scans.
  assign w_cand  = (r_mask & bus.channel_request) >> r_ptr;
  assign w_grant = r_run & w_cand[0] & ~bus.sample_fifo_almost_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= SCAN;
      r_ptr    <= 8'd0;
      r_sel    <= NO_CH;
      r_hold   <= 4'd0;
      r_mask   <= '0;
      r_run    <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (w_cmd) begin
        case (w_op)
          2'b00: r_mask <= '0;
          2'b01: if (w_idx_ok) r_mask <= r_mask | w_idx_bit;
          2'b10: if (w_idx_ok) r_mask <= r_mask & ~w_idx_bit;
          default: r_run <= bus.cmd_bus_data[0];
        endcase
      end

      case (r_state)
        SCAN: begin
          if (w_grant) begin
            r_sel    <= r_ptr;
            r_strobe <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= STROBE;
          end else begin
            r_ptr <= next_ch(r_ptr);
          end
        end
        STROBE: begin
          r_strobe <= 1'b0;
          r_hold   <= HOLD_LD;
          r_state  <= HOLD;
        end
        HOLD: begin
          if (r_hold == 4'd0) begin
            r_sel   <= NO_CH;
            r_busy  <= 1'b0;
            r_ptr   <= next_ch(r_sel);
            r_state <= SCAN;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign bus.channel_select = r_sel;
  assign bus.output_sample  = r_strobe;
  assign bus.busy           = r_busy;

`ifdef SAMPLE_SEQ_STATS_EN
  logic [31:0] r_grant_cnt;

  // A clear command wins over a coincident STROBE increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_cnt <= 32'h0;
    end else if (w_cmd && (w_op == 2'b00)) begin
      r_grant_cnt <= 32'h0;
    end else if (r_state == STROBE) begin
      r_grant_cnt <= r_grant_cnt + 32'h1;
    end
  end

  assign bus.grant_count = r_grant_cnt;
`else
  assign bus.grant_count = 32'h0;
`endif

endmodule

// File: tb/tb_sample_bus_sequencer.sv
module tb_sample_bus_sequencer;

  localparam int NCH  = 50;
  localparam int HOLD = 2;
  localparam int POS  = 242;
`ifdef SAMPLE_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_bus_sequencer_if #(.NUM_CHANNELS(NCH)) bus  ();
  sample_bus_sequencer_if #(.NUM_CHANNELS(1))   bus1 ();

  sample_bus_sequencer #(.POSITION(POS), .NUM_CHANNELS(NCH), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sample_bus_sequencer #(.POSITION(POS), .NUM_CHANNELS(1), .HOLD_CYCLES(HOLD)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  bit         mon_en  = 1'b0;
  logic [7:0] mon_exp;

  typedef struct {
    logic [1:0] op_a;
    logic [7:0] arg_a;
    logic [1:0] op_b;
    logic [7:0] arg_b;
    int         req;
    logic [7:0] exp_sel;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] arg);
    bus.cmd_bus_en   = 1'b1;
    bus.cmd_bus_wr   = 1'b1;
    bus.cmd_bus_addr = 16'(POS);
    bus.cmd_bus_data = {op, 22'd0, arg};
    tick();
    bus.cmd_bus_en   = 1'b0;
    bus.cmd_bus_wr   = 1'b0;
  endtask

  task automatic cmd1(input logic [1:0] op, input logic [7:0] arg);
    bus1.cmd_bus_en   = 1'b1;
    bus1.cmd_bus_wr   = 1'b1;
    bus1.cmd_bus_addr = 16'(POS);
    bus1.cmd_bus_data = {op, 22'd0, arg};
    tick();
    bus1.cmd_bus_en   = 1'b0;
    bus1.cmd_bus_wr   = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.output_sample) seen = 1'b1;
    end
  endtask

  task automatic drain();
    cmd(2'b11, 8'd0);
    repeat (HOLD + 3) tick();
  endtask

  // Scoreboard: every strobe on the main bus must match the next queued channel.
  always @(negedge clk) begin
    if (mon_en && bus.output_sample) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got ch %0d expected no grant", bus.channel_select);
      end else begin
        mon_exp = exp_q.pop_front();
        check("sb_order", {24'd0, bus.channel_select}, {24'd0, mon_exp});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int gap;
    int cnt;

    bus.cmd_bus_en = 1'b0; bus.cmd_bus_wr = 1'b0;
    bus.cmd_bus_addr = 16'd0; bus.cmd_bus_data = 32'd0;
    bus.channel_request = '0; bus.sample_fifo_almost_full = 1'b0;
    bus1.cmd_bus_en = 1'b0; bus1.cmd_bus_wr = 1'b0;
    bus1.cmd_bus_addr = 16'd0; bus1.cmd_bus_data = 32'd0;
    bus1.channel_request = '0; bus1.sample_fifo_almost_full = 1'b0;

    vecs[0] = '{2'b01, 8'd3,  2'b01, 8'd3,  3,  8'd3};
    vecs[1] = '{2'b01, 8'd0,  2'b01, 8'd0,  0,  8'd0};
    vecs[2] = '{2'b01, 8'd49, 2'b01, 8'd49, 49, 8'd49};
    vecs[3] = '{2'b01, 8'd60, 2'b01, 8'd60, 10, 8'hFF};
    vecs[4] = '{2'b01, 8'd8,  2'b10, 8'd8,  8,  8'hFF};
    vecs[5] = '{2'b01, 8'd9,  2'b00, 8'd0,  9,  8'hFF};
    vecs[6] = '{2'b01, 8'd20, 2'b01, 8'd21, 21, 8'd21};
    vecs[7] = '{2'b01, 8'd7,  2'b01, 8'd8,  6,  8'hFF};

    rst = 1'b1;
    repeat (3) tick();
    check("reset_sel",    {24'd0, bus.channel_select}, 32'hFF);
    check("reset_strobe", {31'd0, bus.output_sample},  32'd0);
    check("reset_busy",   {31'd0, bus.busy},           32'd0);
    check("reset_count",  bus.grant_count,             32'd0);
    rst = 1'b0;

    // Table: mask programming followed by a single requester.
    for (int v = 0; v < 8; v++) begin
      cmd(2'b00, 8'd0);
      cmd(vecs[v].op_a, vecs[v].arg_a);
      cmd(vecs[v].op_b, vecs[v].arg_b);
      cmd(2'b11, 8'd1);
      bus.channel_request = '0;
      bus.channel_request[vecs[v].req] = 1'b1;
      wait_strobe(NCH + 10, seen);
      check($sformatf("vec%0d_sel", v), seen ? {24'd0, bus.channel_select} : 32'hFF,
            {24'd0, vecs[v].exp_sel});
      bus.channel_request = '0;
      drain();
    end

    // Single requester on ch 3: strobe, hold, and the full-ring revisit period.
    rst = 1'b1; tick(); rst = 1'b0;
    cmd(2'b01, 8'd3);
    cmd(2'b11, 8'd1);
    bus.channel_request[3] = 1'b1;
    wait_strobe(NCH + 10, seen);
    check("per_first_seen", {31'd0, seen}, 32'd1);
    check("per_first_sel",  {24'd0, bus.channel_select}, 32'd3);
    check("per_first_busy", {31'd0, bus.busy}, 32'd1);
    for (int g = 0; g < 4; g++) begin
      gap = 0;
      do begin
        tick();
        gap++;
        if (g == 0 && gap == 1) begin
          check("per_strobe_1cyc", {31'd0, bus.output_sample}, 32'd0);
          check("per_hold_sel1",   {24'd0, bus.channel_select}, 32'd3);
        end
        if (g == 0 && gap == HOLD)
          check("per_hold_sel2", {24'd0, bus.channel_select}, 32'd3);
        if (g == 0 && gap == HOLD + 1) begin
          check("per_release_sel",  {24'd0, bus.channel_select}, 32'hFF);
          check("per_release_busy", {31'd0, bus.busy}, 32'd0);
        end
      end while (!bus.output_sample && gap < 200);
      // The pointer must sweep the whole ring before it returns to ch 3.
      check("per_gap", gap, 1 + HOLD + NCH);
      check("per_sel", {24'd0, bus.channel_select}, 32'd3);
    end
    drain();
    bus.channel_request = '0;
    check("count_5", bus.grant_count, STATS ? 32'd5 : 32'd0);
    cmd(2'b00, 8'd0);
    check("count_clear", bus.grant_count, 32'd0);

    // Single-channel build: ptr stays 0, re-grant every 2+HOLD cycles.
    cmd1(2'b01, 8'd0);
    cmd1(2'b11, 8'd1);
    bus1.channel_request = 1'b1;
    cnt = 0;
    while (!bus1.output_sample && cnt < 10) begin tick(); cnt++; end
    check("n1_first", {31'd0, bus1.output_sample}, 32'd1);
    for (int g = 0; g < 2; g++) begin
      gap = 0;
      do begin tick(); gap++; end while (!bus1.output_sample && gap < 20);
      check("n1_gap", gap, 2 + HOLD);
      check("n1_sel", {24'd0, bus1.channel_select}, 32'd0);
    end
    bus1.channel_request = 1'b0;

    // Round-robin order. After reset ptr=0 and advances through the three
    // enable commands and the run command (run only counts from the next
    // scan), so the sweep starts at ptr=4: 10, 49, 0, 10.
    rst = 1'b1; tick(); rst = 1'b0;
    mon_en = 1'b1;
    bus.channel_request[0]  = 1'b1;
    bus.channel_request[10] = 1'b1;
    bus.channel_request[49] = 1'b1;
    exp_q.push_back(8'd10); exp_q.push_back(8'd49);
    exp_q.push_back(8'd0);  exp_q.push_back(8'd10);
    cmd(2'b01, 8'd0);
    cmd(2'b01, 8'd10);
    cmd(2'b01, 8'd49);
    cmd(2'b11, 8'd1);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 400) begin tick(); cnt++; end
    check("rr_done", exp_q.size(), 0);
    bus.channel_request[0]  = 1'b0;
    bus.channel_request[10] = 1'b0;
    exp_q.push_back(8'd49);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 400) begin tick(); cnt++; end
    check("rr_wrap49", exp_q.size(), 0);
    drain();
    mon_en = 1'b0;
    bus.channel_request = '0;

    // Back-pressure raised during a strobe.
    cmd(2'b00, 8'd0);
    cmd(2'b01, 8'd7);
    cmd(2'b11, 8'd1);
    bus.channel_request[7] = 1'b1;
    wait_strobe(NCH + 10, seen);
    check("af_first", seen ? {24'd0, bus.channel_select} : 32'hFF, 32'd7);
    bus.sample_fifo_almost_full = 1'b1;
    tick();
    check("af_hold_sel", {24'd0, bus.channel_select}, 32'd7);
    repeat (HOLD) tick();
    check("af_release", {23'd0, bus.busy, bus.channel_select}, 32'h0FF);
    wait_strobe(120, seen);
    check("af_blocked", {31'd0, seen}, 32'd0);
    bus.sample_fifo_almost_full = 1'b0;
    wait_strobe(NCH + 1, seen);
    check("af_resume", seen ? {24'd0, bus.channel_select} : 32'hFF, 32'd7);
    drain();
    bus.channel_request = '0;

    // Disable the granted channel during HOLD.
    cmd(2'b00, 8'd0);
    cmd(2'b01, 8'd12);
    cmd(2'b11, 8'd1);
    bus.channel_request[12] = 1'b1;
    wait_strobe(NCH + 10, seen);
    check("dis_first", seen ? {24'd0, bus.channel_select} : 32'hFF, 32'd12);
    tick();
    cmd(2'b10, 8'd12);
    check("dis_hold_kept", {23'd0, bus.busy, bus.channel_select}, 32'h10C);
    tick();
    check("dis_hold_end", {24'd0, bus.channel_select}, 32'hFF);
    wait_strobe(120, seen);
    check("dis_no_regrant", {31'd0, seen}, 32'd0);
    drain();
    bus.channel_request = '0;

    // Reset held three cycles mid-HOLD.
    cmd(2'b00, 8'd0);
    cmd(2'b01, 8'd5);
    cmd(2'b11, 8'd1);
    bus.channel_request[5] = 1'b1;
    wait_strobe(NCH + 10, seen);
    check("rst_first", seen ? {24'd0, bus.channel_select} : 32'hFF, 32'd5);
    tick();
    rst = 1'b1;
    tick();
    check("rst_sel",    {24'd0, bus.channel_select}, 32'hFF);
    check("rst_strobe", {31'd0, bus.output_sample},  32'd0);
    check("rst_busy",   {31'd0, bus.busy},           32'd0);
    repeat (2) tick();
    rst = 1'b0;
    wait_strobe(120, seen);
    check("rst_no_grant", {31'd0, seen}, 32'd0);
    cmd(2'b01, 8'd5);
    cmd(2'b11, 8'd1);
    wait_strobe(NCH + 10, seen);
    check("rst_regrant", seen ? {24'd0, bus.channel_select} : 32'hFF, 32'd5);
    drain();
    bus.channel_request = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
